register_file: RTL and testbench

Architectural integer register file with a per-register pending-write scoreboard. It is the consumer end of the writeback interface: it accepts the write-back result, destination and regwrite strobe, and serves two combinational read ports to decode. Same-cycle write-to-read bypass is built in. The scoreboard counts in-flight writes per register and raises a stall to decode when an issuing instruction reads a register whose result has not yet reached writeback.

---
 rtl/register_file.sv | 120 ++++++++++++
 tb/tb_register_file.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// Architectural integer register file with write-to-read bypass and a
// per-register pending-write scoreboard that stalls decode on unresolved operands.
module register_file #(
  parameter int NUM_REGS  = 32,
  parameter int DATA_SIZE = 32,
  parameter int PEND_W    = 2
) (
  input  logic                        i_aclk,
  input  logic                        i_areset_n,
  input  logic                        i_wb_regwrite,
  input  logic [$clog2(NUM_REGS)-1:0] i_wb_rdest,
  input  logic signed [DATA_SIZE-1:0] i_wb_data,
  input  logic                        i_wb_release,
  input  logic [$clog2(NUM_REGS)-1:0] i_rs1,
  input  logic [$clog2(NUM_REGS)-1:0] i_rs2,
  output logic signed [DATA_SIZE-1:0] o_rs1_data,
  output logic signed [DATA_SIZE-1:0] o_rs2_data,
  input  logic                        i_issue_valid,
  input  logic                        i_issue_rs1_used,
  input  logic                        i_issue_rs2_used,
  input  logic                        i_issue_regwrite,
  input  logic [$clog2(NUM_REGS)-1:0] i_issue_rdest,
  output logic                        o_stall,
  output logic                        o_sb_error
);

  localparam int AW = $clog2(NUM_REGS);

  logic signed [DATA_SIZE-1:0] r_regs [NUM_REGS];
  logic [PEND_W-1:0]           r_cnt  [NUM_REGS];
  logic                        r_sb_error;

  logic [NUM_REGS-1:0]         w_rel;
  logic [NUM_REGS-1:0]         w_inc;
  logic [NUM_REGS-1:0]         w_pend;
  logic [PEND_W-1:0]           w_cnt_nxt [NUM_REGS];
  logic                        w_err;
  logic                        w_rs1_hazard;
  logic                        w_rs2_hazard;
  logic                        w_rd_full;
  logic                        w_accept;
  logic                        w_wr_en;

  assign w_wr_en = i_wb_regwrite && (i_wb_rdest != '0);

  // Read ports: address 0 is hardwired zero, otherwise bypass a same-cycle write
  always_comb begin
    o_rs1_data = '0;
    if (i_rs1 != '0) begin
      if (w_wr_en && (i_wb_rdest == i_rs1)) o_rs1_data = i_wb_data;
      else                                   o_rs1_data = r_regs[i_rs1];
    end
  end

  always_comb begin
    o_rs2_data = '0;
    if (i_rs2 != '0) begin
      if (w_wr_en && (i_wb_rdest == i_rs2)) o_rs2_data = i_wb_data;
      else                                   o_rs2_data = r_regs[i_rs2];
    end
  end

  // Effective pending (count minus this cycle's release) is positive, computed without wrap
  always_comb begin
    w_rel  = '0;
    w_pend = '0;
    for (int unsigned r = 1; r < NUM_REGS; r++) begin
      w_rel[r]  = i_wb_release && (i_wb_rdest == AW'(r));
      w_pend[r] = (r_cnt[r] != '0) &&
                  ((r_cnt[r] != PEND_W'(1)) || !w_rel[r]);
    end
  end

  always_comb begin
    w_rs1_hazard = i_issue_rs1_used && (i_rs1 != '0) && w_pend[i_rs1];
    w_rs2_hazard = i_issue_rs2_used && (i_rs2 != '0) && w_pend[i_rs2];
    w_rd_full    = i_issue_regwrite && (i_issue_rdest != '0) &&
                   (r_cnt[i_issue_rdest] == '1);
    o_stall      = i_issue_valid && (w_rs1_hazard || w_rs2_hazard || w_rd_full);
    w_accept     = i_issue_valid && !o_stall;
  end

  always_comb begin
    w_inc = '0;
    w_err = 1'b0;
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      w_cnt_nxt[r] = r_cnt[r];
    end
    for (int unsigned r = 1; r < NUM_REGS; r++) begin
      w_inc[r] = w_accept && i_issue_regwrite && (i_issue_rdest == AW'(r));
      case ({w_inc[r], w_rel[r]})
        2'b10:   w_cnt_nxt[r] = r_cnt[r] + PEND_W'(1);
        2'b01: begin
          if (r_cnt[r] == '0) w_err = 1'b1;
          else                w_cnt_nxt[r] = r_cnt[r] - PEND_W'(1);
        end
        default: w_cnt_nxt[r] = r_cnt[r];
      endcase
    end
  end

  always_ff @(posedge i_aclk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
        r_regs[r] <= '0;
        r_cnt[r]  <= '0;
      end
      r_sb_error <= 1'b0;
    end else begin
      if (w_wr_en) r_regs[i_wb_rdest] <= i_wb_data;
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
        r_cnt[r] <= w_cnt_nxt[r];
      end
      if (w_err) r_sb_error <= 1'b1;
    end
  end

  assign o_sb_error = r_sb_error;

endmodule

// File: tb/tb_register_file.sv
// Directed bench: stimulus queues expected outputs, a negedge monitor checks them.
module tb_register_file;

  logic               clk;
  logic               rst_n;
  logic               wb_regwrite;
  logic [4:0]         wb_rdest;
  logic signed [31:0] wb_data;
  logic               wb_release;
  logic [4:0]         rs1, rs2;
  logic signed [31:0] rs1_data, rs2_data;
  logic               iss_valid, iss_rs1_used, iss_rs2_used, iss_regwrite;
  logic [4:0]         iss_rdest;
  logic               stall, sb_error;

  register_file #(.NUM_REGS(32), .DATA_SIZE(32), .PEND_W(2)) dut (
    .i_aclk           (clk),
    .i_areset_n       (rst_n),
    .i_wb_regwrite    (wb_regwrite),
    .i_wb_rdest       (wb_rdest),
    .i_wb_data        (wb_data),
    .i_wb_release     (wb_release),
    .i_rs1            (rs1),
    .i_rs2            (rs2),
    .o_rs1_data       (rs1_data),
    .o_rs2_data       (rs2_data),
    .i_issue_valid    (iss_valid),
    .i_issue_rs1_used (iss_rs1_used),
    .i_issue_rs2_used (iss_rs2_used),
    .i_issue_regwrite (iss_regwrite),
    .i_issue_rdest    (iss_rdest),
    .o_stall          (stall),
    .o_sb_error       (sb_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] r1;
    logic [31:0] r2;
    logic        st;
    logic        er;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      total++;
      if (rs1_data !== e.r1) begin
        bad++;
        $display("FAIL %s rs1_data actual=%h required=%h", e.name, rs1_data, e.r1);
      end
      total++;
      if (rs2_data !== e.r2) begin
        bad++;
        $display("FAIL %s rs2_data actual=%h required=%h", e.name, rs2_data, e.r2);
      end
      total++;
      if (stall !== e.st) begin
        bad++;
        $display("FAIL %s stall actual=%b required=%b", e.name, stall, e.st);
      end
      total++;
      if (sb_error !== e.er) begin
        bad++;
        $display("FAIL %s sb_error actual=%b required=%b", e.name, sb_error, e.er);
      end
    end
  end

  task automatic expect_out(input string n, input logic [31:0] a, input logic [31:0] b,
                            input logic s, input logic e);
    exp_t x;
    x.name = n; x.r1 = a; x.r2 = b; x.st = s; x.er = e;
    q.push_back(x);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wb_regwrite = 0; wb_rdest = 0; wb_data = 0; wb_release = 0;
    rs1 = 0; rs2 = 0;
    iss_valid = 0; iss_rs1_used = 0; iss_rs2_used = 0; iss_regwrite = 0; iss_rdest = 0;
  endtask

  task automatic wb(input logic we, input logic rel, input logic [4:0] rd, input logic [31:0] d);
    wb_regwrite = we; wb_release = rel; wb_rdest = rd; wb_data = d;
  endtask

  task automatic issue(input logic u1, input logic [4:0] a1, input logic u2, input logic [4:0] a2,
                       input logic rw, input logic [4:0] rd);
    iss_valid = 1; iss_rs1_used = u1; rs1 = a1; iss_rs2_used = u2; rs2 = a2;
    iss_regwrite = rw; iss_rdest = rd;
  endtask

  initial begin
    idle();
    rst_n = 0;
    #1;
    expect_out("reset", 0, 0, 0, 0);
    step(); step();
    rst_n = 1;

    // x0 is hardwired zero
    step(); idle(); wb(1, 0, 0, 32'hDEADBEEF);
    expect_out("x0_write", 0, 0, 0, 0);
    step(); idle();
    expect_out("x0_after", 0, 0, 0, 0);

    // bypass then array read
    step(); idle(); wb(1, 0, 5, 32'h12345678); rs1 = 5;
    expect_out("x5_bypass", 32'h12345678, 0, 0, 0);
    step(); idle(); rs1 = 5; rs2 = 5;
    expect_out("x5_array", 32'h12345678, 32'h12345678, 0, 0);

    // RAW dependency on x3 resolved by release
    step(); idle(); issue(0, 0, 0, 0, 1, 3);
    expect_out("iss_rd3", 0, 0, 0, 0);
    step(); idle(); issue(1, 3, 0, 0, 0, 0);
    expect_out("raw_rs1_stall", 0, 0, 1, 0);
    step(); idle(); issue(0, 0, 1, 3, 0, 0);
    expect_out("raw_rs2_stall", 0, 0, 1, 0);
    step(); idle(); issue(1, 3, 0, 0, 0, 0); wb(1, 1, 3, 32'h55);
    expect_out("raw_release", 32'h55, 0, 0, 0);
    step(); idle(); issue(1, 3, 1, 3, 0, 0);
    expect_out("raw_after", 32'h55, 32'h55, 0, 0);

    // saturation on x7
    for (int i = 0; i < 3; i++) begin
      step(); idle(); issue(0, 0, 0, 0, 1, 7);
      expect_out("sat_fill", 0, 0, 0, 0);
    end
    step(); idle(); issue(0, 0, 0, 0, 1, 7);
    expect_out("sat_stall", 0, 0, 1, 0);
    step(); idle(); wb(0, 1, 7, 0);
    expect_out("sat_rel", 0, 0, 0, 0);
    step(); idle(); issue(0, 0, 0, 0, 1, 7); wb(0, 1, 7, 0);
    expect_out("sat_inc_rel", 0, 0, 0, 0);
    step(); idle(); issue(0, 0, 0, 0, 1, 7);
    expect_out("sat_refill", 0, 0, 0, 0);
    step(); idle(); issue(0, 0, 0, 0, 1, 7);
    expect_out("sat_stall2", 0, 0, 1, 0);

    // squashed writeback on x4
    step(); idle(); wb(1, 0, 4, 32'h11);
    expect_out("x4_write", 0, 0, 0, 0);
    step(); idle(); issue(0, 0, 0, 0, 1, 4);
    expect_out("iss_rd4", 0, 0, 0, 0);
    step(); idle(); issue(1, 4, 0, 0, 0, 0); wb(0, 1, 4, 32'h99);
    expect_out("squash_rel", 32'h11, 0, 0, 0);
    step(); idle(); issue(1, 4, 0, 0, 0, 0);
    expect_out("squash_after", 32'h11, 0, 0, 0);

    // release on x0 is ignored; release on idle x9 is an error
    step(); idle(); wb(0, 1, 0, 0);
    expect_out("rel_x0", 0, 0, 0, 0);
    step(); idle(); wb(0, 1, 9, 0);
    expect_out("rel_x9", 0, 0, 0, 0);
    step(); idle();
    expect_out("err_set", 0, 0, 0, 1);
    step(); idle(); rs1 = 5;
    expect_out("err_sticky", 32'h12345678, 0, 0, 1);

    // reset mid-pending
    step(); idle(); issue(0, 0, 0, 0, 1, 3);
    expect_out("iss_rd3b", 0, 0, 0, 1);
    step(); idle(); issue(1, 3, 0, 0, 0, 0); rs2 = 5;
    expect_out("pre_reset", 32'h55, 32'h12345678, 1, 1);
    step();
    rst_n = 0;
    expect_out("mid_reset", 0, 0, 0, 0);
    step(); step();
    rst_n = 1;
    step(); idle(); issue(1, 3, 0, 0, 0, 0); rs2 = 5;
    expect_out("post_reset", 0, 0, 0, 0);

    repeat (2) @(negedge clk);
    #1;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
